mem_stage_v2: RTL and testbench

Parametrised data-memory stage for the RISC-V pipeline, the successor of the current byte-array memory stage. It adds a configurable depth, a configurable number of wait states, and a req/ready/valid handshake. It also provides sign/zero extension for LB/LH/LW/LBU/LHU, alignment and range fault detection, and a hardware memory-clear sequence after reset. Storage is big-endian: the byte at the access address is the most significant byte of the accessed unit. The stage sits between the ALU stage and write-back.

---
 rtl/mem_stage_v2.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_mem_stage_v2.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_v2.sv
// Data-memory stage for the RISC-V pipeline. A word-organised big-endian
// byte memory with a req/ready/valid handshake, optional wait states,
// load sign/zero extension, fault detection and a clear sequence after reset.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_INIT | clearing memory one aligned word per cycle, ready_o low
//   S_IDLE | ready_o high, accepts a request on any edge with req_i high
//   S_BUSY | wait states counting down, access executes at count 1
module mem_stage_v2 #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned WAIT     = 0,
  parameter logic [7:0]  INIT_VAL = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  output logic        ready_o,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] alu_o,
  output logic        fault_o,
  output logic [1:0]  cause_o
);

  localparam int unsigned    NWORDS   = DEPTH / 4;
  localparam int unsigned    WIW      = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [WIW-1:0] LAST_PTR = WIW'(NWORDS - 1);
  localparam logic [32:0]    DEPTH33  = 33'(DEPTH);
  localparam logic [3:0]     WAIT_LD  = 4'(WAIT);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_BUSY} state_t;

  state_t         state_q, state_d;
  logic [WIW-1:0] ptr_q, ptr_d;
  logic [3:0]     cnt_q, cnt_d;

  // captured request, used only when the access executes after wait states
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        valid_q, valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] alu_q, alu_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;

  logic [31:0] mem_q [NWORDS];

  logic        init_we;
  logic        accept;
  logic        exec;

  logic        ex_we;
  logic [1:0]  ex_size;
  logic        ex_uns;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;

  logic [32:0]    nbytes;
  logic           bad_size;
  logic           misal;
  logic           oor;
  logic [1:0]     cause;
  logic           fault;
  logic [WIW-1:0] idx;
  logic [31:0]    rd_word;
  logic [7:0]     ld_byte;
  logic [15:0]    ld_half;
  logic [31:0]    ld_data;
  logic [3:0]     be;
  logic [31:0]    wd;
  logic           st_we;

  assign ready_o = (state_q == S_IDLE);
  assign valid_o = valid_q;
  assign rdata_o = rdata_q;
  assign alu_o   = alu_q;
  assign fault_o = fault_q;
  assign cause_o = cause_q;

  // Next-state logic: clear sequence, request acceptance, wait-state timer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    init_we = 1'b0;
    accept  = 1'b0;
    exec    = 1'b0;
    unique case (state_q)
      S_INIT: begin
        init_we = 1'b1;
        if (ptr_q == LAST_PTR) begin
          ptr_d   = '0;
          state_d = S_IDLE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (req_i) begin
          accept = 1'b1;
          if (WAIT == 0) begin
            exec = 1'b1;
          end else begin
            state_d = S_BUSY;
            cnt_d   = WAIT_LD;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd1) begin
          exec    = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // FSM state, clear pointer and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture on acceptance.
  always_comb begin
    we_d    = accept ? we_i       : we_q;
    size_d  = accept ? size_i     : size_q;
    uns_d   = accept ? unsigned_i : uns_q;
    addr_d  = accept ? addr_i     : addr_q;
    wdata_d = accept ? wdata_i    : wdata_q;
  end

  // Captured request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // With no wait states the access executes straight from the ports.
  always_comb begin
    if (WAIT == 0) begin
      ex_we    = we_i;
      ex_size  = size_i;
      ex_uns   = unsigned_i;
      ex_addr  = addr_i;
      ex_wdata = wdata_i;
    end else begin
      ex_we    = we_q;
      ex_size  = size_q;
      ex_uns   = uns_q;
      ex_addr  = addr_q;
      ex_wdata = wdata_q;
    end
  end

  // Fault classification; the range check is 33-bit so address wrap faults.
  always_comb begin
    unique case (ex_size)
      2'b00:   nbytes = 33'd1;
      2'b01:   nbytes = 33'd2;
      default: nbytes = 33'd4;
    endcase
    bad_size = (ex_size == 2'b11);
    misal    = ((ex_size == 2'b01) && ex_addr[0]) ||
               ((ex_size == 2'b10) && (ex_addr[1:0] != 2'b00));
    oor      = (({1'b0, ex_addr} + nbytes) > DEPTH33);
    if (bad_size)   cause = 2'b11;
    else if (misal) cause = 2'b01;
    else if (oor)   cause = 2'b10;
    else            cause = 2'b00;
    fault = (cause != 2'b00);
  end

  // Load extraction and store lane steering; byte lane 0 is bits [31:24].
  always_comb begin
    idx     = ex_addr[WIW+1:2];
    rd_word = mem_q[idx];
    unique case (ex_addr[1:0])
      2'b00:   ld_byte = rd_word[31:24];
      2'b01:   ld_byte = rd_word[23:16];
      2'b10:   ld_byte = rd_word[15:8];
      default: ld_byte = rd_word[7:0];
    endcase
    ld_half = ex_addr[1] ? rd_word[15:0] : rd_word[31:16];
    unique case (ex_size)
      2'b00: begin
        ld_data = {{24{~ex_uns & ld_byte[7]}}, ld_byte};
        be      = 4'b1000 >> ex_addr[1:0];
        wd      = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        ld_data = {{16{~ex_uns & ld_half[15]}}, ld_half};
        be      = ex_addr[1] ? 4'b0011 : 4'b1100;
        wd      = {2{ex_wdata[15:0]}};
      end
      default: begin
        ld_data = rd_word;
        be      = 4'b1111;
        wd      = ex_wdata;
      end
    endcase
    st_we = exec & ex_we & ~fault;
  end

  // Completion outputs: update on execution, otherwise hold.
  always_comb begin
    valid_d = exec;
    rdata_d = rdata_q;
    alu_d   = alu_q;
    fault_d = fault_q;
    cause_d = cause_q;
    if (exec) begin
      rdata_d = (fault || ex_we) ? 32'h0 : ld_data;
      alu_d   = ex_addr;
      fault_d = fault;
      cause_d = cause;
    end
  end

  // Completion output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rdata_q <= '0;
      alu_q   <= '0;
      fault_q <= 1'b0;
      cause_q <= '0;
    end else begin
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
    end
  end

  // Memory array: cleared only by the INIT sequence, no per-bit reset.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem_q[ptr_q] <= {4{INIT_VAL}};
    end else if (st_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_v2.sv
// Bench for mem_stage_v2: three 16-byte instances with 0, 3 and 2 wait
// states. Expected completions go into a queue when a request is issued and
// are popped and compared, including arrival cycle, when valid_o pulses.
module tb_mem_stage_v2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  int          sel;
  logic [2:0]  req_v;

  logic        rdy [3];
  logic        vld [3];
  logic        flt [3];
  logic [31:0] rd  [3];
  logic [31:0] alu [3];
  logic [1:0]  cs  [3];

  logic        s_rdy, s_vld, s_flt;
  logic [31:0] s_rd, s_alu;
  logic [1:0]  s_cs;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] alu;
    logic        fault;
    logic [1:0]  cause;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   wait_of [3] = '{0, 3, 2};
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    req_v = {req && (sel == 2), req && (sel == 1), req && (sel == 0)};
    s_rdy = rdy[sel];
    s_vld = vld[sel];
    s_flt = flt[sel];
    s_rd  = rd[sel];
    s_alu = alu[sel];
    s_cs  = cs[sel];
  end

  mem_stage_v2 #(.DEPTH(16), .WAIT(0), .INIT_VAL(8'hFF)) u_w0 (
    .clk(clk), .rst_n(rst_n), .req_i(req_v[0]), .ready_o(rdy[0]),
    .we_i(we), .size_i(size), .unsigned_i(uns), .addr_i(addr),
    .wdata_i(wdata), .valid_o(vld[0]), .rdata_o(rd[0]), .alu_o(alu[0]),
    .fault_o(flt[0]), .cause_o(cs[0]));

  mem_stage_v2 #(.DEPTH(16), .WAIT(3), .INIT_VAL(8'hFF)) u_w3 (
    .clk(clk), .rst_n(rst_n), .req_i(req_v[1]), .ready_o(rdy[1]),
    .we_i(we), .size_i(size), .unsigned_i(uns), .addr_i(addr),
    .wdata_i(wdata), .valid_o(vld[1]), .rdata_o(rd[1]), .alu_o(alu[1]),
    .fault_o(flt[1]), .cause_o(cs[1]));

  mem_stage_v2 #(.DEPTH(16), .WAIT(2), .INIT_VAL(8'hFF)) u_w2 (
    .clk(clk), .rst_n(rst_n), .req_i(req_v[2]), .ready_o(rdy[2]),
    .we_i(we), .size_i(size), .unsigned_i(uns), .addr_i(addr),
    .wdata_i(wdata), .valid_o(vld[2]), .rdata_o(rd[2]), .alu_o(alu[2]),
    .fault_o(flt[2]), .cause_o(cs[2]));

  // Scoreboard: every valid pulse of the selected instance pops one entry.
  always @(negedge clk) begin
    if (rst_n && s_vld) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_valid dut=%0d cyc=%0d got rdata=%h alu=%h, required no completion",
                 sel, cyc, s_rd, s_alu);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        n_vec++;
        if (s_rd !== e.rdata) begin
          n_bad++;
          $display("FAIL rdata dut=%0d alu=%h got %h required %h", sel, e.alu, s_rd, e.rdata);
        end
        n_vec++;
        if (s_alu !== e.alu) begin
          n_bad++;
          $display("FAIL alu dut=%0d got %h required %h", sel, s_alu, e.alu);
        end
        n_vec++;
        if (s_flt !== e.fault) begin
          n_bad++;
          $display("FAIL fault dut=%0d alu=%h got %b required %b", sel, e.alu, s_flt, e.fault);
        end
        n_vec++;
        if (s_cs !== e.cause) begin
          n_bad++;
          $display("FAIL cause dut=%0d alu=%h got %b required %b", sel, e.alu, s_cs, e.cause);
        end
        n_vec++;
        if (cyc != e.cyc) begin
          n_bad++;
          $display("FAIL latency dut=%0d alu=%h valid at cyc %0d required cyc %0d", sel, e.alu, cyc, e.cyc);
        end
      end
    end
  end

  // Drive one request; leaves req high so calls can run back-to-back.
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] x_rd, input logic x_f,
                       input logic [1:0] x_c, input bit push);
    int t;
    t = 0;
    @(negedge clk);
    while (!s_rdy && t < 50) begin
      req = 1'b0;
      t++;
      @(negedge clk);
    end
    if (!s_rdy) begin
      n_vec++;
      n_bad++;
      $display("FAIL ready_timeout dut=%0d got ready=%b required 1", sel, s_rdy);
    end
    req   = 1'b1;
    we    = w;
    size  = sz;
    uns   = u;
    addr  = a;
    wdata = wd;
    @(posedge clk);
    #1;
    if (push) sbq.push_back('{x_rd, a, x_f, x_c, cyc + wait_of[sel]});
  endtask

  task automatic req_off();
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout dut=%0d got %0d pending required 0", sel, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    sel   = 0;
    req   = 1'b0;
    we    = 1'b0;
    size  = 2'b10;
    uns   = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if ({rdy[k], vld[k], rd[k], alu[k], flt[k], cs[k]} !== 69'h0) begin
        n_bad++;
        $display("FAIL reset_values dut=%0d got rdy=%b vld=%b rd=%h alu=%h f=%b c=%b required all 0",
                 k, rdy[k], vld[k], rd[k], alu[k], flt[k], cs[k]);
      end
    end
    // request held high across the whole clear sequence
    req   = 1'b1;
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      n_vec++;
      if (s_rdy !== 1'b0 || s_vld !== 1'b0) begin
        n_bad++;
        $display("FAIL init_ready cycle=%0d got ready=%b valid=%b required 0 0", i, s_rdy, s_vld);
      end
    end
    @(negedge clk);
    n_vec++;
    if (s_rdy !== 1'b1 || s_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_ready got ready=%b valid=%b required 1 0", s_rdy, s_vld);
    end
    sbq.push_back('{32'hFFFF_FFFF, 32'h0, 1'b0, 2'b00, cyc + 1});
    @(negedge clk);
    req = 1'b0;
    drain();
  endtask

  task automatic test_wait0_loads();
    sel = 0;
    issue(1'b1, 2'b10, 1'b0, 32'd4, 32'h80A1_B2C3, 32'h0,         1'b0, 2'b00, 1'b1);
    issue(1'b0, 2'b00, 1'b0, 32'd4, 32'h0,         32'hFFFF_FF80, 1'b0, 2'b00, 1'b1);
    issue(1'b0, 2'b00, 1'b1, 32'd4, 32'h0,         32'h0000_0080, 1'b0, 2'b00, 1'b1);
    issue(1'b0, 2'b01, 1'b0, 32'd6, 32'h0,         32'hFFFF_B2C3, 1'b0, 2'b00, 1'b1);
    issue(1'b0, 2'b01, 1'b1, 32'd5, 32'h0,         32'h0,         1'b1, 2'b01, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'd4, 32'h0,         32'h80A1_B2C3, 1'b0, 2'b00, 1'b1);
    issue(1'b0, 2'b01, 1'b0, 32'd4, 32'h0,         32'hFFFF_80A1, 1'b0, 2'b00, 1'b1);
    issue(1'b0, 2'b00, 1'b0, 32'd7, 32'h0,         32'hFFFF_FFC3, 1'b0, 2'b00, 1'b1);
    issue(1'b0, 2'b00, 1'b1, 32'd5, 32'h0,         32'h0000_00A1, 1'b0, 2'b00, 1'b1);
    req_off();
    drain();
  endtask

  task automatic test_subword_store();
    sel = 0;
    issue(1'b1, 2'b00, 1'b0, 32'd15, 32'h0000_005A, 32'h0,         1'b0, 2'b00, 1'b1);
    issue(1'b0, 2'b00, 1'b1, 32'd15, 32'h0,         32'h0000_005A, 1'b0, 2'b00, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'd12, 32'h0,         32'hFFFF_FF5A, 1'b0, 2'b00, 1'b1);
    issue(1'b1, 2'b01, 1'b0, 32'd10, 32'hDEAD_1234, 32'h0,         1'b0, 2'b00, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'd8,  32'h0,         32'hFFFF_1234, 1'b0, 2'b00, 1'b1);
    issue(1'b0, 2'b00, 1'b0, 32'd10, 32'h0,         32'h0000_0012, 1'b0, 2'b00, 1'b1);
    req_off();
    drain();
  endtask

  task automatic test_faults();
    sel = 0;
    issue(1'b1, 2'b10, 1'b0, 32'd16,        32'h1122_3344, 32'h0,         1'b1, 2'b10, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'd0,         32'h0,         32'hFFFF_FFFF, 1'b0, 2'b00, 1'b1);
    issue(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h1122_3344, 32'h0,         1'b1, 2'b10, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'd12,        32'h0,         32'hFFFF_FF5A, 1'b0, 2'b00, 1'b1);
    issue(1'b1, 2'b11, 1'b0, 32'd3,         32'h1122_3344, 32'h0,         1'b1, 2'b11, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'd0,         32'h0,         32'hFFFF_FFFF, 1'b0, 2'b00, 1'b1);
    issue(1'b1, 2'b10, 1'b0, 32'd13,        32'h1122_3344, 32'h0,         1'b1, 2'b01, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'd12,        32'h0,         32'hFFFF_FF5A, 1'b0, 2'b00, 1'b1);
    issue(1'b0, 2'b01, 1'b0, 32'd15,        32'h0,         32'h0,         1'b1, 2'b01, 1'b1);
    issue(1'b0, 2'b00, 1'b0, 32'd16,        32'h0,         32'h0,         1'b1, 2'b10, 1'b1);
    issue(1'b0, 2'b10, 1'b1, 32'd12,        32'h0,         32'hFFFF_FF5A, 1'b0, 2'b00, 1'b1);
    req_off();
    drain();
  endtask

  task automatic test_wait3();
    sel = 1;
    issue(1'b1, 2'b10, 1'b0, 32'd8, 32'hCAFE_BABE, 32'h0, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req = 1'b0;
      n_vec++;
      if (s_rdy !== 1'b0) begin
        n_bad++;
        $display("FAIL busy_ready cycle=%0d got %b required 0", i, s_rdy);
      end
    end
    @(negedge clk);
    n_vec++;
    if (s_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_done_ready got %b required 1", s_rdy);
    end
    issue(1'b0, 2'b10, 1'b0, 32'd8,  32'h0, 32'hCAFE_BABE, 1'b0, 2'b00, 1'b1);
    issue(1'b0, 2'b01, 1'b1, 32'd10, 32'h0, 32'h0000_BABE, 1'b0, 2'b00, 1'b1);
    issue(1'b0, 2'b00, 1'b0, 32'd8,  32'h0, 32'hFFFF_FFCA, 1'b0, 2'b00, 1'b1);
    req_off();
    drain();
  endtask

  task automatic test_reset_busy();
    bit saw;
    int t;
    sel = 2;
    saw = 1'b0;
    issue(1'b1, 2'b10, 1'b0, 32'd0, 32'h1234_5678, 32'h0, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    req   = 1'b0;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (s_vld) saw = 1'b1;
    end
    rst_n = 1'b1;
    t = 0;
    while (!s_rdy && t < 20) begin
      @(negedge clk);
      if (s_vld) saw = 1'b1;
      t++;
    end
    n_vec++;
    if (saw) begin
      n_bad++;
      $display("FAIL aborted_valid got valid=1 required no valid after reset");
    end
    issue(1'b0, 2'b10, 1'b0, 32'd0, 32'h0, 32'hFFFF_FFFF, 1'b0, 2'b00, 1'b1);
    req_off();
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_wait0_loads();
    test_subword_store();
    test_faults();
    test_wait3();
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
